// File: rtl/conv_operand_feeder_if.sv
// Operand pair handshake between the convolution operand feeder and the MAC.
// The feeder drives matched (data, weight) pairs; the MAC answers with pair_ready.
interface conv_operand_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] weight;
  logic              pair_valid;
  logic              pair_ready;

  modport master (output data, output weight, output pair_valid, input pair_ready);
  modport slave  (input data, input weight, input pair_valid, output pair_ready);
endinterface

// File: rtl/conv_operand_feeder.sv
// Walks one KxKxC receptive field, issues feature/weight buffer reads and
// delivers matched operand pairs to the MAC through a 2-entry bypass FIFO.
module conv_operand_feeder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] window_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [15:0]       img_w,
  input  logic [ADDR_W-1:0] plane_size,
  input  logic [3:0]        ksize,
  input  logic [11:0]       channels,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_q,
  input  logic [DATA_W-1:0] weight_q,
  conv_operand_feeder_if.master mac,
  output logic              conv_ready,
  output logic [31:0]       op_num,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [3:0]        k_r;
  logic [11:0]       c_r;
  logic [ADDR_W-1:0] img_w_r;
  logic [ADDR_W-1:0] plane_r;
  logic [3:0]        kx;
  logic [3:0]        ky;
  logic [11:0]       ch;
  logic [ADDR_W-1:0] row_ptr;
  logic [ADDR_W-1:0] chan_ptr;
  logic [19:0]       pairs_left;

  logic              vld_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] fifo_d [2];
  logic [DATA_W-1:0] fifo_w [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic [7:0]        k_sq;
  logic [19:0]       n_total;
  logic              last_kx;
  logic              last_ky;
  logic              last_c;
  logic              bypass;
  logic              xfer;
  logic              push;
  logic              pop_mem;

  // Multiplier only feeds op_num / pair count, never the address path.
  assign k_sq    = 8'(ksize) * 8'(ksize);
  assign n_total = 20'(k_sq) * 20'(channels);

  assign last_kx = (kx == k_r - 4'd1);
  assign last_ky = (ky == k_r - 4'd1);
  assign last_c  = (ch == c_r - 12'd1);

  // p0: read issue, throttled so held pairs plus in-flight reads never exceed 2
  assign vld_p0      = (state == ISSUE) && ((count + {1'b0, vld_p1}) < 2'd2);
  assign rd_en       = vld_p0;

  // p1: read data returns; it bypasses the FIFO when nothing older is queued
  assign bypass         = (count == 2'd0) && vld_p1;
  assign mac.pair_valid = (count != 2'd0) || vld_p1;
  assign mac.data       = bypass ? data_q   : fifo_d[rd_ptr];
  assign mac.weight     = bypass ? weight_q : fifo_w[rd_ptr];
  assign xfer           = mac.pair_valid && mac.pair_ready;
  assign push           = vld_p1 && !(bypass && mac.pair_ready);
  assign pop_mem        = xfer && (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_w[0] <= '0;
      fifo_w[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      vld_p1 <= vld_p0;
      if (push) begin
        fifo_d[wr_ptr] <= data_q;
        fifo_w[wr_ptr] <= weight_q;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_mem) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop_mem};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_r         <= '0;
      c_r         <= '0;
      img_w_r     <= '0;
      plane_r     <= '0;
      kx          <= '0;
      ky          <= '0;
      ch          <= '0;
      row_ptr     <= '0;
      chan_ptr    <= '0;
      pairs_left  <= '0;
      data_addr   <= '0;
      weight_addr <= '0;
      op_num      <= '0;
      conv_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      conv_ready <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_r     <= ksize;
            c_r     <= channels;
            img_w_r <= ADDR_W'(img_w);
            plane_r <= plane_size;
            if (ksize == 4'd0 || channels == 12'd0) begin
              done <= 1'b1;
            end else begin
              op_num      <= 32'(n_total) - 32'd1;
              pairs_left  <= n_total;
              conv_ready  <= 1'b1;
              busy        <= 1'b1;
              kx          <= '0;
              ky          <= '0;
              ch          <= '0;
              data_addr   <= window_base;
              row_ptr     <= window_base;
              chan_ptr    <= window_base;
              weight_addr <= weight_base;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (xfer) pairs_left <= pairs_left - 20'd1;
          if (vld_p0) begin
            weight_addr <= weight_addr + ADDR_W'(1);
            if (!last_kx) begin
              kx        <= kx + 4'd1;
              data_addr <= data_addr + ADDR_W'(1);
            end else if (!last_ky) begin
              kx        <= '0;
              ky        <= ky + 4'd1;
              row_ptr   <= row_ptr + img_w_r;
              data_addr <= row_ptr + img_w_r;
            end else if (!last_c) begin
              kx        <= '0;
              ky        <= '0;
              ch        <= ch + 12'd1;
              chan_ptr  <= chan_ptr + plane_r;
              row_ptr   <= chan_ptr + plane_r;
              data_addr <= chan_ptr + plane_r;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            pairs_left <= pairs_left - 20'd1;
            if (pairs_left == 20'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
